// File: rtl/vr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready requesters into a single
// registered valid/ready output stage, and counts completed downstream beats.
module vr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  input  logic                          out_ready,
  output logic [15:0]                   xfer_count
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]      out_src_q, out_src_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
  logic [15:0]           xfer_count_q, xfer_count_d;

  logic                  found_s;
  logic [SRC_W-1:0]      win_s;
  logic [SRC_W:0]        sum_s;
  logic [SRC_W:0]        cand_s;
  logic                  can_load_s;
  logic                  grant_s;
  logic                  down_xfer_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  // Circular priority search starting after last_grant; walking the offsets
  // from farthest to nearest lets the nearest valid requester overwrite the rest.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum_s   = {1'b0, last_grant_q} + (SRC_W+1)'(k);
      cand_s  = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
      win_s   = req_valid[cand_s[SRC_W-1:0]] ? cand_s[SRC_W-1:0] : win_s;
      found_s = found_s | req_valid[cand_s[SRC_W-1:0]];
    end
  end

  // Handshake decode; reset forces every ready low so nothing is accepted.
  always_comb begin
    can_load_s  = !out_valid_q || out_ready;
    grant_s     = found_s && can_load_s && rst_n;
    down_xfer_s = out_valid_q && out_ready;
    req_ready_s = '0;
    if (grant_s) begin
      req_ready_s[win_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Data mux for the winning requester.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = (win_s == SRC_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
    end
  end

  // Next-state for the output stage, grant pointer and transfer counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    xfer_count_d = down_xfer_s ? (xfer_count_q + 16'd1) : xfer_count_q;
    if (grant_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = sel_data_s;
      out_src_d    = win_s;
      last_grant_d = win_s;
    end else if (down_xfer_s) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= LAST_IDX;
      xfer_count_q <= 16'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign req_ready  = req_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign xfer_count = xfer_count_q;

endmodule
